// File: rtl/arb2_rr_sel.sv
// arb2_rr_sel: two-source round-robin packet arbiter driving a 2:1 mux select.
// A grant is held for a whole packet. Ownership rotates on packet end. If the
// other source is waiting, ownership also rotates after HOLD_MAX beats.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_a, last_a      source A beat available / beat ends A's packet
//   req_b, last_b      source B beat available / beat ends B's packet
//   out_ready          downstream accepts a beat this cycle
//   sel                registered mux select (0=A, 1=B)
//   gnt_a, gnt_b       registered ownership flags
//   out_valid          combinational: owner has a beat available
//   beat_cnt           registered beats transferred in the current grant
module arb2_rr_sel #(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CW       = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          last_a,
    input  logic          req_b,
    input  logic          last_b,
    input  logic          out_ready,
    output logic          sel,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          out_valid,
    output logic [CW-1:0] beat_cnt
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX == 0 ? 0 : HOLD_MAX - 1);
    localparam logic          HOLD_EN   = (HOLD_MAX != 0);

    state_t          state, state_nx;
    logic            sel_nx;
    logic [CW-1:0]   cnt_nx;
    logic            last_owner, last_owner_nx;   // 0=A, 1=B
    logic            beat;
    logic            at_limit;

    // Round-robin pick. lo is the last owner (1=B). On a tie the other source wins.
    function automatic state_t pick(input logic ra, input logic rb, input logic lo);
        if (ra && rb) return lo ? OWN_A : OWN_B;
        else if (ra)  return OWN_A;
        else if (rb)  return OWN_B;
        else          return IDLE;
    endfunction

    assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
    assign beat      = out_valid & out_ready;
    assign at_limit  = HOLD_EN && (beat_cnt == HOLD_LAST);

    // Next-state, counter and select logic
    always_comb begin
        state_nx      = state;
        sel_nx        = sel;
        cnt_nx        = beat_cnt;
        last_owner_nx = last_owner;
        case (state)
            IDLE: state_nx = pick(req_a, req_b, last_owner);
            OWN_A: begin
                if (beat) begin
                    if (last_a || (at_limit && req_b)) begin
                        last_owner_nx = 1'b0;
                        cnt_nx        = '0;
                        state_nx      = pick(req_a, req_b, 1'b0);
                    end else if (beat_cnt != CNT_MAX) begin
                        cnt_nx = beat_cnt + CW'(1);
                    end
                end
            end
            OWN_B: begin
                if (beat) begin
                    if (last_b || (at_limit && req_a)) begin
                        last_owner_nx = 1'b1;
                        cnt_nx        = '0;
                        state_nx      = pick(req_a, req_b, 1'b1);
                    end else if (beat_cnt != CNT_MAX) begin
                        cnt_nx = beat_cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
        // sel follows the new owner; in IDLE it keeps its last value
        if (state_nx == OWN_A)      sel_nx = 1'b0;
        else if (state_nx == OWN_B) sel_nx = 1'b1;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= 1'b0;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            beat_cnt   <= '0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nx;
            sel        <= sel_nx;
            gnt_a      <= (state_nx == OWN_A);
            gnt_b      <= (state_nx == OWN_B);
            beat_cnt   <= cnt_nx;
            last_owner <= last_owner_nx;
        end
    end

endmodule

// File: tb/tb_arb2_rr_sel.sv
// tb_arb2_rr_sel: directed bench for arb2_rr_sel with HOLD_MAX=16, CW=5.
module tb_arb2_rr_sel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, last_a, req_b, last_b, out_ready;
    logic       sel, gnt_a, gnt_b, out_valid;
    logic [4:0] beat_cnt;

    int total = 0;
    int bad   = 0;

    arb2_rr_sel #(.HOLD_MAX(16), .CW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .last_a(last_a), .req_b(req_b), .last_b(last_b),
        .out_ready(out_ready),
        .sel(sel), .gnt_a(gnt_a), .gnt_b(gnt_b),
        .out_valid(out_valid), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_a = 1'b0; last_a = 1'b0; req_b = 1'b0; last_b = 1'b0; out_ready = 1'b1;
        #4;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_a = 1'b0; last_a = 1'b0; req_b = 1'b0; last_b = 1'b0; out_ready = 1'b0;
        #7;
        total++; if ({gnt_a, gnt_b, sel, out_valid} !== 4'b0000) begin bad++;
            $display("FAIL reset_flags got=%b exp=0000", {gnt_a, gnt_b, sel, out_valid}); end
        total++; if (beat_cnt !== 5'd0) begin bad++;
            $display("FAIL reset_cnt got=%0d exp=0", beat_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_a();
        do_reset();
        req_a = 1'b1;
        #1;
        total++; if ({gnt_a, out_valid} !== 2'b00) begin bad++;
            $display("FAIL single_idle got=%b exp=00", {gnt_a, out_valid}); end
        step();
        total++; if ({gnt_a, gnt_b, sel, out_valid} !== 4'b1001) begin bad++;
            $display("FAIL single_grant got=%b exp=1001", {gnt_a, gnt_b, sel, out_valid}); end
        step();
        total++; if (beat_cnt !== 5'd1) begin bad++;
            $display("FAIL single_cnt got=%0d exp=1", beat_cnt); end
        // last with no other requester: A is re-granted, counter restarts
        last_a = 1'b1;
        step();
        total++; if ({gnt_a, sel, beat_cnt} !== {1'b1, 1'b0, 5'd0}) begin bad++;
            $display("FAIL single_regrant got=%b/%b/%0d exp=1/0/0", gnt_a, sel, beat_cnt); end
    endtask

    task automatic test_contention();
        do_reset();
        req_a = 1'b1; req_b = 1'b1;
        step();
        total++; if ({gnt_a, gnt_b, sel} !== 3'b100) begin bad++;
            $display("FAIL cont_first got=%b exp=100", {gnt_a, gnt_b, sel}); end
        // B's last is ignored while A owns
        last_b = 1'b1;
        step();
        total++; if ({gnt_a, beat_cnt} !== {1'b1, 5'd1}) begin bad++;
            $display("FAIL cont_ignore_last got=%b/%0d exp=1/1", gnt_a, beat_cnt); end
        last_b = 1'b0; last_a = 1'b1;
        step();
        total++; if ({gnt_a, gnt_b, sel, out_valid} !== 4'b0111) begin bad++;
            $display("FAIL cont_handover got=%b exp=0111", {gnt_a, gnt_b, sel, out_valid}); end
        total++; if (beat_cnt !== 5'd0) begin bad++;
            $display("FAIL cont_handover_cnt got=%0d exp=0", beat_cnt); end
        last_a = 1'b0; last_b = 1'b1;
        step();
        total++; if ({gnt_a, gnt_b, sel} !== 3'b100) begin bad++;
            $display("FAIL cont_back_to_a got=%b exp=100", {gnt_a, gnt_b, sel}); end
    endtask

    task automatic test_ready_toggle();
        logic [4:0] exp_cnt [4] = '{5'd1, 5'd1, 5'd2, 5'd2};
        logic       rdy     [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        req_a = 1'b1; out_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            out_ready = rdy[i];
            step();
            total++; if ({beat_cnt, sel, gnt_a} !== {exp_cnt[i], 1'b0, 1'b1}) begin bad++;
                $display("FAIL ready_toggle[%0d] got=%0d/%b/%b exp=%0d/0/1", i, beat_cnt, sel, gnt_a, exp_cnt[i]); end
        end
    endtask

    task automatic test_force();
        do_reset();
        req_a = 1'b1; req_b = 1'b1;
        step();
        repeat (15) step();
        total++; if ({gnt_a, beat_cnt} !== {1'b1, 5'd15}) begin bad++;
            $display("FAIL force_before got=%b/%0d exp=1/15", gnt_a, beat_cnt); end
        step();
        total++; if ({gnt_a, gnt_b, sel, beat_cnt} !== {3'b011, 5'd0}) begin bad++;
            $display("FAIL force_rotate got=%b/%0d exp=011/0", {gnt_a, gnt_b, sel}, beat_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        req_a = 1'b1;
        step();
        repeat (16) step();
        total++; if ({gnt_a, beat_cnt} !== {1'b1, 5'd16}) begin bad++;
            $display("FAIL no_force_alone got=%b/%0d exp=1/16", gnt_a, beat_cnt); end
        repeat (24) step();
        total++; if ({gnt_a, beat_cnt} !== {1'b1, 5'd31}) begin bad++;
            $display("FAIL saturate got=%b/%0d exp=1/31", gnt_a, beat_cnt); end
    endtask

    task automatic test_hold_b();
        do_reset();
        req_b = 1'b1;
        step();
        step();
        req_b = 1'b0; req_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({gnt_b, out_valid, sel, beat_cnt} !== {3'b101, 5'd1}) begin bad++;
                $display("FAIL hold_b[%0d] got=%b/%0d exp=101/1", i, {gnt_b, out_valid, sel}, beat_cnt); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_a = 1'b1;
        step();
        repeat (5) step();
        total++; if (beat_cnt !== 5'd5) begin bad++;
            $display("FAIL mid_pre got=%0d exp=5", beat_cnt); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({gnt_a, sel, beat_cnt} !== {2'b00, 5'd0}) begin bad++;
            $display("FAIL mid_reset got=%b/%b/%0d exp=0/0/0", gnt_a, sel, beat_cnt); end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_contention();
        test_ready_toggle();
        test_force();
        test_saturate();
        test_hold_b();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
